secure_mem_requester: RTL and testbench

Initiator-side controller that drives the secure memory's rd_en/wr_en/addr/wrData interface and consumes its rdData/rdData_valid return. It accepts one host request at a time through a valid/ready handshake and issues the matching single-cycle memory strobe. It waits for read data with a bounded timeout and returns data or an error through a valid/ready response channel. Write-protected key slots and a global write lock are enforced before any write reaches memory.

---
 rtl/secure_mem_requester.sv | 179 +++++++++++++++++
 tb/tb_secure_mem_requester.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_mem_requester.sv
`default_nettype none
// ============================================================================
//  Module   : secure_mem_requester
//  Purpose  : Initiator-side controller for the secure key memory. Accepts one
//             host request at a time (valid/ready), issues a single-cycle
//             rd_en/wr_en strobe, waits for read data with a bounded timeout
//             and returns data or an error on a valid/ready response channel.
//             Writes to protected slots or while wr_lock is set are refused
//             before anything reaches the memory.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             req_valid/ready/write/addr/wdata, wr_lock - host request side
//             rsp_valid/ready/data/err      - host response side
//             mem_rd_en/wr_en/addr/wrData   - registered memory command
//             mem_rdData/rdData_valid       - memory read return
//  Revision : 1.0 - initial release
// ============================================================================
module secure_mem_requester #(
    parameter int                WIDTH     = 256,
    parameter int                LENGTH    = 16,
    parameter logic [LENGTH-1:0] PROT_MASK = 16'h3C04,
    parameter int                TIMEOUT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [$clog2(LENGTH)-1:0] req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    input  logic                      wr_lock,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic [$clog2(LENGTH)-1:0] mem_addr,
    output logic [WIDTH-1:0]          mem_wrData,
    input  logic [WIDTH-1:0]          mem_rdData,
    input  logic                      mem_rdData_valid
);

    localparam int c_AW = $clog2(LENGTH);
    localparam int c_CW = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_WRITE    = 3'd1;
    localparam logic [2:0] c_S_RD_ISSUE = 3'd2;
    localparam logic [2:0] c_S_RD_WAIT  = 3'd3;
    localparam logic [2:0] c_S_RESP     = 3'd4;

    logic [2:0]       r_state_q,     w_state_d;
    logic [c_CW-1:0]  r_cnt_q,       w_cnt_d;
    logic             r_rsp_valid_q, w_rsp_valid_d;
    logic             r_rsp_err_q,   w_rsp_err_d;
    logic [WIDTH-1:0] r_rsp_data_q,  w_rsp_data_d;
    logic             r_rd_en_q,     w_rd_en_d;
    logic             r_wr_en_q,     w_wr_en_d;
    logic [c_AW-1:0]  r_addr_q,      w_addr_d;
    logic [WIDTH-1:0] r_wdata_q,     w_wdata_d;

    logic w_accept;
    logic w_reject;

    assign req_ready = (r_state_q == c_S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    // Refused writes never touch the memory command registers.
    assign w_reject  = req_write && (PROT_MASK[req_addr] || wr_lock);

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_err_d   = r_rsp_err_q;
        w_rsp_data_d  = r_rsp_data_q;
        // Strobes, address and write data are only non-zero for the single
        // cycle of the strobe so key material does not linger on the bus.
        w_rd_en_d     = 1'b0;
        w_wr_en_d     = 1'b0;
        w_addr_d      = '0;
        w_wdata_d     = '0;

        case (r_state_q)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (!req_write) begin
                        w_state_d = c_S_RD_ISSUE;
                        w_rd_en_d = 1'b1;
                        w_addr_d  = req_addr;
                    end else if (w_reject) begin
                        w_state_d     = c_S_RESP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_data_d  = '0;
                    end else begin
                        w_state_d = c_S_WRITE;
                        w_wr_en_d = 1'b1;
                        w_addr_d  = req_addr;
                        w_wdata_d = req_wdata;
                    end
                end
            end
            c_S_WRITE: begin
                w_state_d     = c_S_RESP;
                w_rsp_valid_d = 1'b1;
                w_rsp_err_d   = 1'b0;
                w_rsp_data_d  = '0;
            end
            c_S_RD_ISSUE: begin
                w_state_d = c_S_RD_WAIT;
                w_cnt_d   = '0;
            end
            c_S_RD_WAIT: begin
                w_cnt_d = r_cnt_q + c_CW'(1);
                // Data arriving on the last permitted cycle still wins.
                if (mem_rdData_valid) begin
                    w_state_d     = c_S_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = 1'b0;
                    w_rsp_data_d  = mem_rdData;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d     = c_S_RESP;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_data_d  = '0;
                end
            end
            c_S_RESP: begin
                if (rsp_ready) begin
                    w_state_d     = c_S_IDLE;
                    w_rsp_valid_d = 1'b0;
                    w_rsp_err_d   = 1'b0;
                    w_rsp_data_d  = '0;
                end
            end
            default: begin
                w_state_d     = c_S_IDLE;
                w_rsp_valid_d = 1'b0;
                w_rsp_err_d   = 1'b0;
                w_rsp_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_S_IDLE;
            r_cnt_q       <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_err_q   <= 1'b0;
            r_rsp_data_q  <= '0;
            r_rd_en_q     <= 1'b0;
            r_wr_en_q     <= 1'b0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_rd_en_q     <= w_rd_en_d;
            r_wr_en_q     <= w_wr_en_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
        end
    end

    assign rsp_valid  = r_rsp_valid_q;
    assign rsp_err    = r_rsp_err_q;
    assign rsp_data   = r_rsp_data_q;
    assign mem_rd_en  = r_rd_en_q;
    assign mem_wr_en  = r_wr_en_q;
    assign mem_addr   = r_addr_q;
    assign mem_wrData = r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_secure_mem_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_secure_mem_requester
//  Purpose  : Self-checking bench for secure_mem_requester. A memory stub with
//             programmable read delay sits on the memory port; a reference
//             model tracks memory contents, protection and expected response
//             timing for directed and random request sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_secure_mem_requester;

    localparam int          c_WIDTH   = 256;
    localparam int          c_LENGTH  = 16;
    localparam int          c_AW      = 4;
    localparam int          c_TIMEOUT = 8;
    localparam logic [15:0] c_PROT    = 16'h3C04;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid, req_ready, req_write, wr_lock;
    logic [c_AW-1:0]     req_addr;
    logic [c_WIDTH-1:0]  req_wdata;
    logic                rsp_valid, rsp_ready, rsp_err;
    logic [c_WIDTH-1:0]  rsp_data;
    logic                mem_rd_en, mem_wr_en;
    logic [c_AW-1:0]     mem_addr;
    logic [c_WIDTH-1:0]  mem_wrData, mem_rdData;
    logic                mem_rdData_valid;

    always #5 clk = ~clk;

    secure_mem_requester #(
        .WIDTH     (c_WIDTH),
        .LENGTH    (c_LENGTH),
        .PROT_MASK (c_PROT),
        .TIMEOUT   (c_TIMEOUT)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .wr_lock          (wr_lock),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .mem_rd_en        (mem_rd_en),
        .mem_wr_en        (mem_wr_en),
        .mem_addr         (mem_addr),
        .mem_wrData       (mem_wrData),
        .mem_rdData       (mem_rdData),
        .mem_rdData_valid (mem_rdData_valid)
    );

    // Deterministic power-on contents shared by stub and reference model.
    function automatic logic [c_WIDTH-1:0] init_word(input int idx);
        logic [c_WIDTH-1:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = (32'h9E3779B9 * (idx * 8 + k + 1)) ^ 32'h5A5A0000;
        return w;
    endfunction

    // ---------------- memory stub: read data arrives stub_delay cycles after
    // the cycle rd_en is high; stub_delay == 0 means it never answers.
    logic [c_WIDTH-1:0] stub_mem [c_LENGTH];
    logic               stub_load;
    int                 stub_delay;
    int                 pend;
    logic [c_WIDTH-1:0] pend_data, stub_rdata;
    logic               stub_valid;
    logic               spur;
    logic [c_WIDTH-1:0] spur_data;

    assign mem_rdData       = spur ? spur_data : stub_rdata;
    assign mem_rdData_valid = stub_valid | spur;

    always @(posedge clk) begin
        if (stub_load) begin
            for (int i = 0; i < c_LENGTH; i++) stub_mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            stub_mem[mem_addr] <= mem_wrData;
        end
        stub_valid <= 1'b0;
        if (rst) begin
            pend       <= 0;
            stub_rdata <= '0;
        end else if (mem_rd_en) begin
            pend      <= (stub_delay > 1) ? stub_delay - 1 : 0;
            pend_data <= stub_mem[mem_addr];
            if (stub_delay == 1) begin
                stub_valid <= 1'b1;
                stub_rdata <= stub_mem[mem_addr];
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                stub_valid <= 1'b1;
                stub_rdata <= pend_data;
            end
        end
    end

    // ---------------- reference model and checking
    logic [c_WIDTH-1:0] ref_mem [c_LENGTH];
    logic [15:0]        prot_mask;
    int                 n_total = 0;
    int                 n_bad   = 0;

    task automatic chk(input string tag, input logic [c_WIDTH-1:0] got, input logic [c_WIDTH-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wrData"}, mem_wrData, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete request/response; expectations come from the model.
    task automatic run_txn(input logic wr, input logic [c_AW-1:0] addr, input logic [c_WIDTH-1:0] wdata,
                           input logic lock, input int delay, input int hold);
        logic               exp_err;
        logic [c_WIDTH-1:0] exp_data;
        int                 exp_lat, exp_rd, exp_wr;
        int                 lat, rd_cnt, wr_cnt, guard;
        logic               got_rsp;

        if (wr) begin
            exp_err  = prot_mask[addr] | lock;
            exp_data = '0;
            exp_lat  = exp_err ? 1 : 2;
            exp_wr   = exp_err ? 0 : 1;
            exp_rd   = 0;
            if (!exp_err) ref_mem[addr] = wdata;
        end else begin
            exp_rd = 1;
            exp_wr = 0;
            if (delay >= 1 && delay <= c_TIMEOUT) begin
                exp_err  = 1'b0;
                exp_data = ref_mem[addr];
                exp_lat  = delay + 2;
            end else begin
                exp_err  = 1'b1;
                exp_data = '0;
                exp_lat  = c_TIMEOUT + 2;
            end
        end

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", req_ready, 1);
        stub_delay = delay;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        wr_lock    = lock;
        @(negedge clk);
        // Scramble request inputs: the DUT must have captured them at accept.
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = c_AW'($urandom);
        req_wdata = {8{$urandom}};
        wr_lock   = 1'($urandom);

        lat = 1; rd_cnt = 0; wr_cnt = 0; got_rsp = 1'b0;
        while (!got_rsp && lat <= 30) begin
            chk("both_strobes", mem_rd_en & mem_wr_en, 0);
            if (mem_wr_en) begin
                wr_cnt++;
                chk("wr_addr", mem_addr, addr);
                chk("wr_data", mem_wrData, wdata);
            end
            if (mem_rd_en) begin
                rd_cnt++;
                chk("rd_addr", mem_addr, addr);
            end
            if (rsp_valid) got_rsp = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("latency", lat, exp_lat);
        chk("rd_pulses", rd_cnt, exp_rd);
        chk("wr_pulses", wr_cnt, exp_wr);
        if (!got_rsp) begin
            do_reset();
            return;
        end
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", rsp_err, exp_err);

        for (int i = 0; i < hold; i++) begin
            spur      = 1'($urandom);
            spur_data = {8{$urandom}};
            @(negedge clk);
            spur = 1'b0;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_err", rsp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", rsp_valid, 0);
        chk("post_data", rsp_data, 0);
        chk("post_err", rsp_err, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_wrData", mem_wrData, 0);
    endtask

    int dtab [10] = '{1, 1, 1, 2, 3, 5, 8, 9, 0, 4};

    initial begin
        prot_mask = c_PROT;
        for (int i = 0; i < c_LENGTH; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; stub_load = 1'b1; stub_delay = 1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        wr_lock = 1'b0; rsp_ready = 1'b0; spur = 1'b0; spur_data = '0;

        // Reset state, including req_ready held low while rst is high.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        chk("reset_req_ready", req_ready, 0);
        rst = 1'b0; stub_load = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // Directed sequence.
        run_txn(1'b0, 4'd2,  '0,               1'b0, 1, 0);  // plain read
        run_txn(1'b1, 4'd5,  {32{8'hA5}},      1'b0, 1, 0);  // write
        run_txn(1'b0, 4'd5,  '0,               1'b0, 1, 0);  // readback
        run_txn(1'b1, 4'd10, {8{32'hDEADBEEF}}, 1'b0, 1, 0); // protected slot
        run_txn(1'b1, 4'd5,  {8{32'h12345678}}, 1'b1, 1, 0); // global lock
        run_txn(1'b0, 4'd10, '0,               1'b0, 1, 0);  // protected slot untouched
        run_txn(1'b0, 4'd5,  '0,               1'b0, 1, 0);  // locked write dropped
        run_txn(1'b0, 4'd7,  '0,               1'b0, 0, 0);  // memory never answers
        run_txn(1'b0, 4'd6,  '0,               1'b0, c_TIMEOUT, 0);     // data on last cycle
        run_txn(1'b0, 4'd6,  '0,               1'b0, c_TIMEOUT + 1, 0); // one cycle too late
        run_txn(1'b0, 4'd3,  '0,               1'b0, 1, 5);  // slow host

        // Reset while waiting for read data.
        @(negedge clk);
        stub_delay = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        chk("midrst_req_ready", req_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        run_txn(1'b0, 4'd11, '0, 1'b0, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), c_AW'($urandom), {8{$urandom}},
                    ($urandom_range(0, 7) == 0), dtab[$urandom_range(0, 9)],
                    $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
